sdram_pattern_tester: RTL and testbench

Self-checking traffic generator that sits directly upstream of `sdram_top` and drives its write/read request ports. It fills an address window with a pass-dependent pattern, reads it back in bursts and compares every word. It reports error count, first failing address and pass count for the board-level display logic. It replaces the single-word accumulator used for first bring-up with a full-window memory test.

---
 rtl/sdram_pattern_tester.sv | 187 ++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: fills [ADDR_FIRST..ADDR_LAST] with a pass-keyed pattern, reads it back in bursts and scores every word.
// Latency: start -> first write request after 3 cycles; done/pass_ok 1 cycle after the last read ack.
// Backpressure: a burst is issued only while sdram_busy=0; beats advance only on sdram_wr_ack/sdram_rd_ack.
module sdram_pattern_tester #(
  parameter logic [23:0] ADDR_FIRST = 24'h000000,
  parameter logic [23:0] ADDR_LAST  = 24'h0003FF,
  parameter int unsigned BURST      = 8
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        start,
  input  logic        loop,
  output logic        busy,
  output logic        done,
  output logic        pass_ok,
  output logic [15:0] err_count,
  output logic [23:0] first_err_addr,
  output logic [15:0] pass_count,
  input  logic        sdram_init_done,
  input  logic        sdram_busy,
  output logic        sdram_wr_req,
  output logic [23:0] sdram_wr_addr,
  output logic [15:0] sdram_wr_data,
  output logic [8:0]  sdwr_bytes,
  input  logic        sdram_wr_ack,
  output logic        sdram_rd_req,
  output logic [23:0] sdram_rd_addr,
  output logic [8:0]  sdrd_bytes,
  input  logic        sdram_rd_ack,
  input  logic [15:0] sdram_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_INIT, S_WR_ISSUE, S_WR_XFER, S_RD_ISSUE, S_RD_XFER, S_CHECK
  } state_t;

  // Window bounds widened to 25 bits so a window ending at 24'hFFFFFF cannot wrap.
  localparam logic [24:0] LAST_W  = {1'b0, ADDR_LAST};
  localparam logic [24:0] BURST_W = 25'(BURST);

  state_t      state_q, state_d;
  logic [23:0] addr_q, addr_d;          // base address of the current burst
  logic [8:0]  beat_q, beat_d;          // beat index inside the burst
  logic [8:0]  len_q, len_d;            // n of the current burst
  logic [15:0] err_count_q, err_count_d;
  logic [23:0] first_err_q, first_err_d;
  logic [15:0] pass_count_q, pass_count_d;
  logic        pass_ok_q, pass_ok_d;

  logic [24:0] remain, next_base;
  logic [8:0]  burst_n;
  logic [23:0] beat_addr;
  logic [15:0] exp_word;
  logic        last_beat, last_burst, abort, run_done;

  // Burst geometry, expected word of the current beat, abort and completion qualifiers.
  always_comb begin
    remain     = LAST_W - {1'b0, addr_q} + 25'd1;
    burst_n    = (remain < BURST_W) ? remain[8:0] : BURST_W[8:0];
    next_base  = {1'b0, addr_q} + {16'd0, len_q};
    last_burst = (next_base > LAST_W);
    last_beat  = (beat_q == len_q - 9'd1);
    beat_addr  = addr_q + {15'd0, beat_q};
    exp_word   = beat_addr[15:0] ^ {pass_count_q[7:0], pass_count_q[7:0]} ^ 16'hA5C3;
    // WAIT_INIT legitimately sees init_done=0; anywhere later a low init_done means it fell.
    abort      = !sdram_init_done && (state_q != S_IDLE) && (state_q != S_WAIT_INIT);
    run_done   = (state_q == S_CHECK) && !loop && sdram_init_done;
  end

  // State and datapath registers.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      len_q        <= '0;
      err_count_q  <= '0;
      first_err_q  <= '0;
      pass_count_q <= '0;
      pass_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
      err_count_q  <= err_count_d;
      first_err_q  <= first_err_d;
      pass_count_q <= pass_count_d;
      pass_ok_q    <= pass_ok_d;
    end
  end

  // Next-state: write the window, read it back, then loop or finish; init loss aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_WAIT_INIT;
      S_WAIT_INIT: if (sdram_init_done) state_d = S_WR_ISSUE;
      S_WR_ISSUE:  if (!sdram_busy) state_d = S_WR_XFER;
      S_WR_XFER:   if (sdram_wr_ack && last_beat) state_d = last_burst ? S_RD_ISSUE : S_WR_ISSUE;
      S_RD_ISSUE:  if (!sdram_busy) state_d = S_RD_XFER;
      S_RD_XFER:   if (sdram_rd_ack && last_beat) state_d = last_burst ? S_CHECK : S_RD_ISSUE;
      S_CHECK:     state_d = loop ? S_WR_ISSUE : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Datapath next values: burst walk, read compare, error scoring and pass bookkeeping.
  always_comb begin
    addr_d       = addr_q;
    beat_d       = beat_q;
    len_d        = len_q;
    err_count_d  = err_count_q;
    first_err_d  = first_err_q;
    pass_count_d = pass_count_q;
    pass_ok_d    = pass_ok_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_count_d = '0;
          first_err_d = '0;
          pass_ok_d   = 1'b0;
        end
      end
      S_WAIT_INIT: begin
        addr_d = ADDR_FIRST;
        beat_d = '0;
      end
      S_WR_ISSUE, S_RD_ISSUE: begin
        if (!sdram_busy) begin
          len_d  = burst_n;
          beat_d = '0;
        end
      end
      S_WR_XFER: begin
        if (sdram_wr_ack) begin
          if (last_beat) begin
            beat_d = '0;
            addr_d = last_burst ? ADDR_FIRST : next_base[23:0];
          end else begin
            beat_d = beat_q + 9'd1;
          end
        end
      end
      S_RD_XFER: begin
        if (sdram_rd_ack) begin
          if (sdram_rd_data != exp_word) begin
            // err_count is still zero only before the first mismatch of the run.
            if (err_count_q == 16'd0) first_err_d = beat_addr;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          end
          if (last_beat) begin
            beat_d = '0;
            addr_d = last_burst ? ADDR_FIRST : next_base[23:0];
            // Counting on entry to CHECK makes pass_count already final while done is high.
            if (last_burst) pass_count_d = pass_count_q + 16'd1;
          end else begin
            beat_d = beat_q + 9'd1;
          end
        end
      end
      S_CHECK: begin
        if (run_done) pass_ok_d = (err_count_q == 16'd0);
      end
      default: ;
    endcase
  end

  // Outputs: requests follow the XFER states; done/pass_ok are visible in the CHECK cycle itself.
  always_comb begin
    sdram_wr_req   = (state_q == S_WR_XFER);
    sdram_rd_req   = (state_q == S_RD_XFER);
    sdram_wr_addr  = addr_q;
    sdram_rd_addr  = addr_q;
    sdwr_bytes     = len_q;
    sdrd_bytes     = len_q;
    sdram_wr_data  = ((state_q == S_WR_ISSUE) || (state_q == S_WR_XFER)) ? exp_word : 16'd0;
    done           = run_done;
    busy           = (state_q != S_IDLE) && !run_done;
    pass_ok        = pass_ok_q || (run_done && (err_count_q == 16'd0));
    err_count      = err_count_q;
    first_err_addr = first_err_q;
    pass_count     = pass_count_q;
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
module tb_sdram_pattern_tester;

  logic clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Instance A: window 0..9, BURST 4
  logic        a_start, a_loop, a_busy, a_done, a_pass_ok, a_init, a_sdbusy;
  logic [15:0] a_err, a_pcnt, a_wr_data, a_rd_data;
  logic [23:0] a_first, a_wr_addr, a_rd_addr;
  logic        a_wr_req, a_wr_ack, a_rd_req, a_rd_ack;
  logic [8:0]  a_wr_bytes, a_rd_bytes;

  // Instance B: window 24'hFFFFFC..24'hFFFFFF, BURST 8
  logic        b_start, b_busy, b_done, b_pass_ok;
  logic [15:0] b_err, b_pcnt, b_wr_data, b_rd_data;
  logic [23:0] b_first, b_wr_addr, b_rd_addr;
  logic        b_wr_req, b_wr_ack, b_rd_req, b_rd_ack;
  logic [8:0]  b_wr_bytes, b_rd_bytes;

  sdram_pattern_tester #(.ADDR_FIRST(24'h000000), .ADDR_LAST(24'h000009), .BURST(4)) dut_a (
    .clk_100m(clk_100m), .rst_n(rst_n), .start(a_start), .loop(a_loop),
    .busy(a_busy), .done(a_done), .pass_ok(a_pass_ok), .err_count(a_err),
    .first_err_addr(a_first), .pass_count(a_pcnt),
    .sdram_init_done(a_init), .sdram_busy(a_sdbusy),
    .sdram_wr_req(a_wr_req), .sdram_wr_addr(a_wr_addr), .sdram_wr_data(a_wr_data),
    .sdwr_bytes(a_wr_bytes), .sdram_wr_ack(a_wr_ack),
    .sdram_rd_req(a_rd_req), .sdram_rd_addr(a_rd_addr), .sdrd_bytes(a_rd_bytes),
    .sdram_rd_ack(a_rd_ack), .sdram_rd_data(a_rd_data)
  );

  sdram_pattern_tester #(.ADDR_FIRST(24'hFFFFFC), .ADDR_LAST(24'hFFFFFF), .BURST(8)) dut_b (
    .clk_100m(clk_100m), .rst_n(rst_n), .start(b_start), .loop(1'b0),
    .busy(b_busy), .done(b_done), .pass_ok(b_pass_ok), .err_count(b_err),
    .first_err_addr(b_first), .pass_count(b_pcnt),
    .sdram_init_done(1'b1), .sdram_busy(1'b0),
    .sdram_wr_req(b_wr_req), .sdram_wr_addr(b_wr_addr), .sdram_wr_data(b_wr_data),
    .sdwr_bytes(b_wr_bytes), .sdram_wr_ack(b_wr_ack),
    .sdram_rd_req(b_rd_req), .sdram_rd_addr(b_rd_addr), .sdrd_bytes(b_rd_bytes),
    .sdram_rd_ack(b_rd_ack), .sdram_rd_data(b_rd_data)
  );

  function automatic logic [15:0] pat(input logic [23:0] a, input logic [15:0] p);
    return a[15:0] ^ {p[7:0], p[7:0]} ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] corr(input int mode, input logic [23:0] a);
    if (mode == 1 && a == 24'd5) return 16'h0001;
    if (mode == 1 && a == 24'd7) return 16'h0100;
    if (mode == 2) return 16'hFFFF;
    return 16'h0000;
  endfunction

  // Zero-latency SDRAM models: ack every cycle the request is high.
  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:3];
  logic [8:0]  a_wbeat = '0, a_rbeat = '0, b_wbeat = '0, b_rbeat = '0;
  logic [23:0] a_wa, a_ra, b_wa, b_ra;
  int          corr_mode = 0;
  bit          stale_mode = 1'b0;
  logic [32:0] a_wlog[$], a_rlog[$], b_wlog[$], b_rlog[$];
  int          last_rd_cyc = 0;

  assign a_wr_ack  = a_wr_req;
  assign a_rd_ack  = a_rd_req;
  assign b_wr_ack  = b_wr_req;
  assign b_rd_ack  = b_rd_req;
  assign a_wa      = a_wr_addr + {15'd0, a_wbeat};
  assign a_ra      = a_rd_addr + {15'd0, a_rbeat};
  assign b_wa      = b_wr_addr + {15'd0, b_wbeat};
  assign b_ra      = b_rd_addr + {15'd0, b_rbeat};
  assign a_rd_data = mem_a[a_ra[9:0]] ^ corr(corr_mode, a_ra);
  assign b_rd_data = mem_b[b_ra[1:0]];

  always @(posedge clk_100m) begin
    cyc <= cyc + 1;
    if (a_wr_req) begin
      // In stale mode, writes of the pass-1 pattern are lost so pass 1 reads pass-0 data.
      if (!(stale_mode && a_wr_data == pat(a_wa, 16'd1))) mem_a[a_wa[9:0]] <= a_wr_data;
      if (a_wbeat == 9'd0) a_wlog.push_back({a_wr_addr, a_wr_bytes});
      a_wbeat <= a_wbeat + 9'd1;
    end else a_wbeat <= '0;
    if (a_rd_req) begin
      if (a_rbeat == 9'd0) a_rlog.push_back({a_rd_addr, a_rd_bytes});
      a_rbeat <= a_rbeat + 9'd1;
      last_rd_cyc <= cyc;
    end else a_rbeat <= '0;
    if (b_wr_req) begin
      mem_b[b_wa[1:0]] <= b_wr_data;
      if (b_wbeat == 9'd0) b_wlog.push_back({b_wr_addr, b_wr_bytes});
      b_wbeat <= b_wbeat + 9'd1;
    end else b_wbeat <= '0;
    if (b_rd_req) begin
      if (b_rbeat == 9'd0) b_rlog.push_back({b_rd_addr, b_rd_bytes});
      b_rbeat <= b_rbeat + 9'd1;
    end else b_rbeat <= '0;
  end

  // Done monitors, sampled mid-cycle.
  int          a_done_cnt = 0, b_done_cnt = 0, done_cyc = 0;
  logic        d_pass_ok, d_busy;
  logic [15:0] d_err, d_pcnt;
  logic [23:0] d_first;
  always @(negedge clk_100m) begin
    if (a_done) begin
      a_done_cnt++;
      done_cyc  = cyc;
      d_pass_ok = a_pass_ok;
      d_busy    = a_busy;
      d_err     = a_err;
      d_pcnt    = a_pcnt;
      d_first   = a_first;
    end
    if (b_done) b_done_cnt++;
  end

  logic [32:0] exp_log [0:2] = '{{24'd0, 9'd4}, {24'd4, 9'd4}, {24'd8, 9'd2}};

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_100m);
    rst_n = 1'b1;
    a_wlog.delete(); a_rlog.delete(); b_wlog.delete(); b_rlog.delete();
  endtask

  task automatic pulse_a_start();
    @(negedge clk_100m); a_start = 1'b1;
    @(negedge clk_100m); a_start = 1'b0;
  endtask

  task automatic wait_a_done(input int base, input string name);
    int n = 0;
    while (a_done_cnt == base && n < 3000) begin @(negedge clk_100m); n++; end
    vectors++;
    if (a_done_cnt == base) begin
      miscompares++;
      $display("FAIL %s_done_timeout: done count %0d, required above %0d", name, a_done_cnt, base);
    end
    repeat (3) @(negedge clk_100m);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100m);
    vectors++;
    if ({a_busy, a_done, a_pass_ok, a_wr_req, a_rd_req} !== 5'b0) begin miscompares++;
      $display("FAIL reset_flags: got %b, required 00000", {a_busy, a_done, a_pass_ok, a_wr_req, a_rd_req}); end
    vectors++;
    if ({a_err, a_first, a_pcnt} !== 56'd0) begin miscompares++;
      $display("FAIL reset_counters: err %h first %h pass %h, required 0", a_err, a_first, a_pcnt); end
    vectors++;
    if ({a_wr_addr, a_rd_addr, a_wr_data, a_wr_bytes, a_rd_bytes} !== 82'd0) begin miscompares++;
      $display("FAIL reset_bus: wa %h ra %h wd %h wn %0d rn %0d, required 0", a_wr_addr, a_rd_addr, a_wr_data, a_wr_bytes, a_rd_bytes); end
    vectors++;
    if ({b_busy, b_wr_req, b_rd_req, b_wr_addr, b_wr_data, b_wr_bytes} !== 52'd0) begin miscompares++;
      $display("FAIL reset_b: busy %b wreq %b rreq %b wa %h wd %h", b_busy, b_wr_req, b_rd_req, b_wr_addr, b_wr_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = a_done_cnt;
    pulse_a_start();
    vectors++;
    if ({a_busy, a_wr_req} !== 2'b10) begin miscompares++;
      $display("FAIL start_t1: busy/req %b, required 10", {a_busy, a_wr_req}); end
    @(negedge clk_100m);
    vectors++;
    if (a_wr_req !== 1'b0) begin miscompares++; $display("FAIL start_t2: wr_req %b, required 0", a_wr_req); end
    @(negedge clk_100m);
    vectors++;
    if ({a_wr_req, a_wr_addr, a_wr_bytes, a_wr_data} !== {1'b1, 24'd0, 9'd4, 16'hA5C3}) begin miscompares++;
      $display("FAIL start_t3: req %b addr %h n %0d data %h, required 1 000000 4 a5c3", a_wr_req, a_wr_addr, a_wr_bytes, a_wr_data); end
    @(negedge clk_100m);
    vectors++;
    if (a_wr_data !== 16'hA5C2) begin miscompares++; $display("FAIL wr_word1: data %h, required a5c2", a_wr_data); end
    wait_a_done(base, "basic");
    vectors++;
    if (a_done_cnt != base + 1) begin miscompares++; $display("FAIL basic_done_count: %0d pulses, required 1", a_done_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (a_wlog.size() != 3 || a_rlog.size() != 3 || a_wlog[i] !== exp_log[i] || a_rlog[i] !== exp_log[i]) begin
        miscompares++;
        $display("FAIL basic_burst%0d: wr sz %0d rd sz %0d, required 3 bursts of {addr,n} %h", i, a_wlog.size(), a_rlog.size(), exp_log[i]);
      end
    end
    vectors++;
    if ({d_pass_ok, d_busy, d_err, d_pcnt} !== {1'b1, 1'b0, 16'd0, 16'd1}) begin miscompares++;
      $display("FAIL basic_at_done: pass_ok %b busy %b err %0d pass %0d, required 1 0 0 1", d_pass_ok, d_busy, d_err, d_pcnt); end
    vectors++;
    if (done_cyc - last_rd_cyc != 1) begin miscompares++;
      $display("FAIL basic_done_latency: %0d cycles after last read ack, required 1", done_cyc - last_rd_cyc); end
    vectors++;
    if ({a_pass_ok, a_busy, a_pcnt} !== {1'b1, 1'b0, 16'd1}) begin miscompares++;
      $display("FAIL basic_after: pass_ok %b busy %b pass %0d, required 1 0 1", a_pass_ok, a_busy, a_pcnt); end
    for (int a = 0; a < 10; a++) begin
      vectors++;
      if (mem_a[a] !== pat(24'(a), 16'd0)) begin miscompares++;
        $display("FAIL basic_mem%0d: got %h, required %h", a, mem_a[a], pat(24'(a), 16'd0)); end
    end
  endtask

  task automatic test_errors();
    int n = 0;
    int base;
    do_reset();
    corr_mode = 1;
    base = a_done_cnt;
    pulse_a_start();
    // start while busy must not clear the score
    while (a_rlog.size() < 3 && n < 500) begin @(negedge clk_100m); n++; end
    pulse_a_start();
    wait_a_done(base, "errors");
    vectors++;
    if ({d_err, d_first, d_pass_ok} !== {16'd2, 24'd5, 1'b0}) begin miscompares++;
      $display("FAIL errors_score: err %0d first %h pass_ok %b, required 2 000005 0", d_err, d_first, d_pass_ok); end
    vectors++;
    if ({a_err, a_first, a_pass_ok, a_done_cnt - base} !== {16'd2, 24'd5, 1'b0, 32'd1}) begin miscompares++;
      $display("FAIL errors_after: err %0d first %h pass_ok %b dones %0d, required 2 000005 0 1", a_err, a_first, a_pass_ok, a_done_cnt - base); end
    corr_mode = 0;
  endtask

  task automatic test_loop_stale();
    int n = 0;
    int base;
    do_reset();
    stale_mode = 1'b1;
    a_loop = 1'b1;
    base = a_done_cnt;
    pulse_a_start();
    while (a_rlog.size() < 9 && n < 3000) begin @(negedge clk_100m); n++; end
    a_loop = 1'b0;
    wait_a_done(base, "loop");
    vectors++;
    if ({d_err, d_first, d_pcnt, d_pass_ok} !== {16'd10, 24'd0, 16'd3, 1'b0}) begin miscompares++;
      $display("FAIL loop_score: err %0d first %h pass %0d pass_ok %b, required 10 000000 3 0", d_err, d_first, d_pcnt, d_pass_ok); end
    vectors++;
    if (a_done_cnt - base != 1 || a_wlog.size() != 9 || a_rlog.size() != 9) begin miscompares++;
      $display("FAIL loop_counts: dones %0d wr %0d rd %0d, required 1 9 9", a_done_cnt - base, a_wlog.size(), a_rlog.size()); end
    stale_mode = 1'b0;
  endtask

  task automatic test_sdram_busy();
    int n = 0;
    int req_bad = 0;
    int base;
    do_reset();
    base = a_done_cnt;
    pulse_a_start();
    while (!(a_wlog.size() == 1 && !a_wr_req) && n < 500) begin @(negedge clk_100m); n++; end
    a_sdbusy = 1'b1;
    repeat (20) begin
      @(negedge clk_100m);
      if (a_wr_req !== 1'b0) req_bad++;
    end
    a_sdbusy = 1'b0;
    vectors++;
    if (req_bad != 0 || a_wlog.size() != 1) begin miscompares++;
      $display("FAIL busy_hold: req high in %0d cycles, bursts %0d, required 0 and 1", req_bad, a_wlog.size()); end
    n = 0;
    while (!a_rd_req && n < 500) begin @(negedge clk_100m); n++; end
    a_sdbusy = 1'b1;
    @(negedge clk_100m);
    vectors++;
    if (a_rd_req !== 1'b1) begin miscompares++; $display("FAIL busy_in_xfer: rd_req %b, required 1", a_rd_req); end
    a_sdbusy = 1'b0;
    wait_a_done(base, "busy");
    vectors++;
    if (a_wlog.size() != 3 || a_wlog[1] !== exp_log[1] || a_wlog[2] !== exp_log[2] || a_rlog.size() != 3) begin miscompares++;
      $display("FAIL busy_bursts: wr %0d rd %0d, required 3 3 with addr/n 4/4 8/2", a_wlog.size(), a_rlog.size()); end
    vectors++;
    if ({d_err, d_pass_ok} !== {16'd0, 1'b1}) begin miscompares++;
      $display("FAIL busy_result: err %0d pass_ok %b, required 0 1", d_err, d_pass_ok); end
    for (int a = 0; a < 10; a++) begin
      vectors++;
      if (mem_a[a] !== pat(24'(a), 16'd0)) begin miscompares++;
        $display("FAIL busy_mem%0d: got %h, required %h", a, mem_a[a], pat(24'(a), 16'd0)); end
    end
  endtask

  task automatic test_abort();
    int n = 0;
    int base;
    do_reset();
    base = a_done_cnt;
    pulse_a_start();
    while (!(a_rlog.size() == 2 && a_rd_req) && n < 500) begin @(negedge clk_100m); n++; end
    a_init = 1'b0;
    @(negedge clk_100m);
    vectors++;
    if ({a_rd_req, a_wr_req, a_busy} !== 3'b000) begin miscompares++;
      $display("FAIL abort_next: rd %b wr %b busy %b, required 000", a_rd_req, a_wr_req, a_busy); end
    repeat (10) @(negedge clk_100m);
    vectors++;
    if (a_done_cnt != base || a_pass_ok !== 1'b0 || a_busy !== 1'b0) begin miscompares++;
      $display("FAIL abort_quiet: dones %0d pass_ok %b busy %b, required 0 0 0", a_done_cnt - base, a_pass_ok, a_busy); end
    a_init = 1'b1;
    pulse_a_start();
    wait_a_done(base, "abort_rerun");
    vectors++;
    if ({d_err, d_pass_ok, a_pass_ok} !== {16'd0, 1'b1, 1'b1}) begin miscompares++;
      $display("FAIL abort_rerun: err %0d pass_ok %b/%b, required 0 1 1", d_err, d_pass_ok, a_pass_ok); end
  endtask

  task automatic test_saturation();
    int n = 0;
    int base;
    do_reset();
    corr_mode = 2;
    base = a_done_cnt;
    pulse_a_start();
    while (!a_wr_req && n < 500) begin @(negedge clk_100m); n++; end
    // Preload the score near the ceiling; the 10 corrupted reads then cross it.
    dut_a.err_count_q = 16'hFFFC;
    wait_a_done(base, "sat");
    vectors++;
    if ({a_err, a_pass_ok} !== {16'hFFFF, 1'b0}) begin miscompares++;
      $display("FAIL saturation: err %h pass_ok %b, required ffff 0", a_err, a_pass_ok); end
    corr_mode = 0;
  endtask

  task automatic test_high_window();
    int n = 0;
    int base;
    do_reset();
    base = b_done_cnt;
    @(negedge clk_100m); b_start = 1'b1;
    @(negedge clk_100m); b_start = 1'b0;
    while (b_done_cnt == base && n < 500) begin @(negedge clk_100m); n++; end
    repeat (5) @(negedge clk_100m);
    vectors++;
    if (b_done_cnt != base + 1) begin miscompares++; $display("FAIL high_done: %0d pulses, required 1", b_done_cnt - base); end
    vectors++;
    if (b_wlog.size() != 1 || b_rlog.size() != 1 || b_wlog[0] !== {24'hFFFFFC, 9'd4} || b_rlog[0] !== {24'hFFFFFC, 9'd4}) begin
      miscompares++;
      $display("FAIL high_bursts: wr %0d rd %0d, required exactly one burst at fffffc n=4 each", b_wlog.size(), b_rlog.size());
    end
    vectors++;
    if ({b_err, b_pass_ok, b_pcnt} !== {16'd0, 1'b1, 16'd1}) begin miscompares++;
      $display("FAIL high_result: err %0d pass_ok %b pass %0d, required 0 1 1", b_err, b_pass_ok, b_pcnt); end
  endtask

  initial begin
    rst_n = 1'b0; a_start = 1'b0; a_loop = 1'b0; a_init = 1'b1; a_sdbusy = 1'b0; b_start = 1'b0;
    test_reset();
    test_basic();
    test_errors();
    test_loop_stale();
    test_sdram_busy();
    test_abort();
    test_saturation();
    test_high_window();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
